// File: rtl/weight_rom_stream_ctrl.sv
// Streams every word of a fixed-latency weight ROM in address order for a programmable
// number of passes, using credit-limited reads into a small skid FIFO on the output.
module weight_rom_stream_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH       = 576,
  parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PASS_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] pass_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 2) + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [PASS_WIDTH-1:0]   passes;
  logic [ROM_LATENCY-1:0]  infl, infl_next;
  logic [ROM_LATENCY-1:0]  infl_last, infl_last_next;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   mem_last;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count, fifo_after_pop, fifo_count_next, inflight_count;
  logic                    push, pop, issue, issue_last, at_end;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Output stream: a beat transfers on a cycle where data_out_valid and data_out_ready
  // are both high; while valid is high and ready low, data_out/data_out_last hold.
  assign data_out_valid = (fifo_count != '0);
  assign data_out       = mem[rd_ptr];
  assign data_out_last  = data_out_valid & mem_last[rd_ptr];
  assign pop            = data_out_valid & data_out_ready;
  assign push           = infl[ROM_LATENCY-1];

  assign rom_addr = addr;
  assign rom_ce   = (state != S_IDLE);
  assign busy     = (state == S_STREAM) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  // Credit check counts words already buffered plus reads still inside the ROM.
  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight_count = inflight_count + CNT_W'(infl[i]);
    end
    fifo_after_pop  = fifo_count - CNT_W'(pop);
    fifo_count_next = fifo_after_pop + CNT_W'(push);
    issue = (state == S_STREAM) &&
            (fifo_after_pop + inflight_count + CNT_W'(1) <= CNT_W'(FIFO_DEPTH));
    at_end     = (addr == ADDR_WIDTH'(DEPTH - 1));
    issue_last = issue && at_end && (passes <= PASS_WIDTH'(1));
  end

  always_comb begin
    infl_next         = '0;
    infl_last_next    = '0;
    infl_next[0]      = issue;
    infl_last_next[0] = issue_last;
    for (int i = 1; i < ROM_LATENCY; i++) begin
      infl_next[i]      = infl[i-1];
      infl_last_next[i] = infl_last[i-1];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_STREAM;
      S_STREAM: if (issue_last) state_next = S_DRAIN;
      S_DRAIN:  if (inflight_count == '0 && fifo_count_next == '0) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      passes     <= '0;
      infl       <= '0;
      infl_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state      <= state_next;
      infl       <= infl_next;
      infl_last  <= infl_last_next;
      fifo_count <= fifo_count_next;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (state == S_IDLE && start) begin
        addr   <= '0;
        passes <= (pass_count == '0) ? PASS_WIDTH'(1) : pass_count;
      end else if (issue) begin
        if (at_end) begin
          addr   <= '0;
          passes <= passes - PASS_WIDTH'(1);
        end else begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Storage needs no reset: an entry is only read once fifo_count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= rom_q;
      mem_last[wr_ptr] <= infl_last[ROM_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_weight_rom_stream_ctrl.sv
// Directed bench for weight_rom_stream_ctrl with a 4-word ROM (word[i] = i + 0x10)
// modelled as a two-stage read pipeline advancing on rom_ce.
module tb_weight_rom_stream_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   pass_count = '0;
  logic          busy, done, rom_ce, data_out_valid, data_out_last;
  logic          data_out_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q, data_out;
  logic [DW-1:0] rom_s1 = '0, rom_s2 = '0;

  logic [W-1:0]  exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;

  weight_rom_stream_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW),
    .ROM_LATENCY(2), .FIFO_DEPTH(4), .PASS_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pass_count(pass_count),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last)
  );

  // clock and ROM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ce) begin
      rom_s1 <= 16'(rom_addr) + 16'h0010;
      rom_s2 <= rom_s1;
    end
  end
  assign rom_q = rom_s2;

  // driver tasks
  task automatic start_run(input logic [15:0] pc);
    @(posedge clk); #1;
    start = 1'b1;
    pass_count = pc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fill_golden(input int beats);
    exp_q.delete();
    for (int k = 0; k < beats; k++) begin
      exp_q.push_back({(k == beats - 1), DW'(16'h0010 + 16'(k % 4))});
    end
  endtask

  task automatic test_reset;
    logic [4:0] got;
    rst = 1'b1; start = 1'b1; pass_count = 16'd5; data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {busy, done, data_out_valid, data_out_last, rom_ce};
    n_cmp++;
    if (got !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=00000", got);
    end
    n_cmp++;
    if (rom_addr !== '0) begin
      n_err++; $display("FAIL reset_addr got=%0d exp=0", rom_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, rom_ce} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle busy/ce=%b exp=00", {busy, rom_ce});
    end
  endtask

  // start at cycle 0: issues 1..4, valid 4..7, last 7, done 8
  task automatic test_single(input logic [15:0] pc, input string name);
    logic [4:0]    got, expv;
    logic [AW-1:0] exp_addr;
    @(posedge clk); #1;
    start = 1'b1; pass_count = pc; data_out_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      expv = {(c >= 4 && c <= 7), (c == 7), (c == 8), (c >= 1 && c <= 7), (c >= 1 && c <= 8)};
      got  = {data_out_valid, data_out_last, done, busy, rom_ce};
      n_cmp++;
      if (got !== expv) begin
        n_err++; $display("FAIL %s_ctrl cycle=%0d got=%b exp=%b (valid,last,done,busy,ce)", name, c, got, expv);
      end
      exp_addr = (c >= 1 && c <= 4) ? AW'(c - 1) : '0;
      n_cmp++;
      if (rom_addr !== exp_addr) begin
        n_err++; $display("FAIL %s_addr cycle=%0d got=%0d exp=%0d", name, c, rom_addr, exp_addr);
      end
      if (c >= 4 && c <= 7) begin
        n_cmp++;
        if (data_out !== DW'(16'h0010 + 16'(c - 4))) begin
          n_err++; $display("FAIL %s_data cycle=%0d got=%h exp=%h", name, c, data_out, 16'h0010 + 16'(c - 4));
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic test_multi;
    logic [W-1:0] e;
    int dones = 0;
    data_out_ready = 1'b1;
    fill_golden(12);
    start_run(16'd3);
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (data_out_valid && data_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL multi_extra got=%h exp=none", data_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out_last, data_out} !== e) begin
            n_err++; $display("FAIL multi_beat got=%h exp=%h", {data_out_last, data_out}, e);
          end
        end
      end
      if (done) dones++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL multi_missing got=%0d left exp=0", exp_q.size());
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++; $display("FAIL multi_done got=%0d exp=1", dones);
    end
  endtask

  // shared body for stalled and random-ready streams over two passes
  task automatic test_backpressure(input logic random_ready, input string name);
    logic [W-1:0]  e;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          prev_stall = 1'b0;
    int            dones = 0;
    data_out_ready = 1'b0;
    fill_golden(8);
    start_run(16'd2);
    for (int c = 1; c < 150; c++) begin
      @(negedge clk);
      if (!random_ready && c >= 6 && c <= 20) begin
        n_cmp++;
        if (rom_addr !== '0) begin
          n_err++; $display("FAIL %s_addr_frozen cycle=%0d got=%0d exp=0", name, c, rom_addr);
        end
      end
      if (!random_ready && c == 20) begin
        n_cmp++;
        if ({data_out_valid, data_out_last, data_out} !== {2'b10, 16'h0010}) begin
          n_err++; $display("FAIL %s_held got=%h exp=%h", name, {data_out_valid, data_out_last, data_out}, {2'b10, 16'h0010});
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if ({data_out_valid, data_out_last, data_out} !== {1'b1, prev_last, prev_data}) begin
          n_err++; $display("FAIL %s_stable cycle=%0d got=%h exp=%h", name, c,
                            {data_out_valid, data_out_last, data_out}, {1'b1, prev_last, prev_data});
        end
      end
      if (data_out_valid && data_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s_extra got=%h exp=none", name, data_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out_last, data_out} !== e) begin
            n_err++; $display("FAIL %s_beat got=%h exp=%h", name, {data_out_last, data_out}, e);
          end
        end
      end
      if (done) dones++;
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = data_out;
      prev_last  = data_out_last;
      @(posedge clk); #1;
      data_out_ready = random_ready ? 1'($urandom_range(0, 1)) : (c >= 20);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s_missing got=%0d left exp=0", name, exp_q.size());
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++; $display("FAIL %s_done got=%0d exp=1", name, dones);
    end
    data_out_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    logic [4:0] got;
    data_out_ready = 1'b1;
    start_run(16'd3);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got = {data_out_valid, busy, rom_ce, done, data_out_last};
    n_cmp++;
    if (got !== 5'b0) begin
      n_err++; $display("FAIL midrst_ctrl got=%b exp=00000 (valid,busy,ce,done,last)", got);
    end
    n_cmp++;
    if (rom_addr !== '0) begin
      n_err++; $display("FAIL midrst_addr got=%0d exp=0", rom_addr);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (data_out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_stale cycle=%0d valid=%b exp=0", c, data_out_valid);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] e;
    int dones = 0;
    data_out_ready = 1'b1;
    fill_golden(4);
    start_run(16'd1);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (data_out_valid && data_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL ignore_extra got=%h exp=none", data_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out_last, data_out} !== e) begin
            n_err++; $display("FAIL ignore_beat got=%h exp=%h", {data_out_last, data_out}, e);
          end
        end
      end
      if (done) dones++;
      @(posedge clk); #1;
      start = (c < 4);
      pass_count = 16'd3;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL ignore_missing got=%0d left exp=0", exp_q.size());
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++; $display("FAIL ignore_done got=%0d exp=1", dones);
    end
  endtask

  initial begin
    test_reset();
    test_single(16'd1, "single");
    test_single(16'd0, "zero_pass");
    test_multi();
    test_backpressure(1'b0, "stall");
    test_backpressure(1'b1, "random");
    test_reset_mid();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
